// File: rtl/nibble_serial_loader.sv
// Purpose: serial (start, 4 data LSB-first, [parity], stop) to 4-bit parallel loader for the 4-bit register.
// Latency: data/enable update one clk after the mid-stop-bit sample; pulses are registered.
// Backpressure: none; the consumer register must accept every enable strobe.
// Optional feature: define NIBBLE_PARITY_CHECK_EN to add an even-parity bit between data and stop.
module nibble_serial_loader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic [3:0] data,
    output logic       enable,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    // Period counter end values: full bit period and half period (start-bit centring).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       shift_q, shift_d;
    logic [3:0]       data_q, data_d;
    logic             enable_q, enable_d;
    logic             frame_err_q, frame_err_d;
    logic             par_bad;
    logic             stop_sample;
    logic             frame_good;

`ifdef NIBBLE_PARITY_CHECK_EN
    logic             par_err_q, par_err_d;
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    // State register plus datapath flops; synchronous active-low reset abandons any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            shift_q     <= 4'h0;
            data_q      <= 4'h0;
            enable_q    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef NIBBLE_PARITY_CHECK_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            enable_q    <= enable_d;
            frame_err_q <= frame_err_d;
`ifdef NIBBLE_PARITY_CHECK_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // Next-state logic: bit timing, shift register assembly and frame sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef NIBBLE_PARITY_CHECK_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = 2'd0;
`ifdef NIBBLE_PARITY_CHECK_EN
                par_err_d = 1'b0;
`endif
                if (!sin) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the start bit half a period in; a high line means a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = sin ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sin;
                    idx_d          = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
`ifdef NIBBLE_PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef NIBBLE_PARITY_CHECK_EN
            PARITY: begin
                // Even parity: data bits XOR parity bit must be zero.
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (^shift_q) ^ sin;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            STOP: begin
                // A low stop sample means the line may be in break; wait for it to recover.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = sin ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (sin) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Output logic: at the stop sample either load the word or flag the frame, never both.
    always_comb begin
        stop_sample = (state_q == STOP) && (cnt_q == CNT_LAST);
        frame_good  = stop_sample && sin && !par_bad;
        enable_d    = frame_good;
        frame_err_d = stop_sample && !frame_good;
        data_d      = frame_good ? shift_q : data_q;
    end

    assign data      = data_q;
    assign enable    = enable_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_serial_loader.sv
// Purpose: directed, table-driven checks of nibble_serial_loader framing, pulses and reset.
// Latency: frames take FRAME_CLKS clk; results are read after a short idle gap.
// Backpressure: not applicable; the bench drives the serial line freely.
module tb_nibble_serial_loader;

    localparam int CPB = 4;
`ifdef NIBBLE_PARITY_CHECK_EN
    localparam int FRAME_CLKS = 7 * CPB;
`else
    localparam int FRAME_CLKS = 6 * CPB;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin   = 1'b1;
    logic [3:0] data;
    logic       enable;
    logic       frame_err;
    logic       busy;

    nibble_serial_loader #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (8)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (sin),
        .data     (data),
        .enable   (enable),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running cycle count and output monitor (sampled on the falling edge).
    int         cyc         = 0;
    int         en_total    = 0;
    int         fe_total    = 0;
    int         both_hi     = 0;
    int         data_glitch = 0;
    int         en_cyc_last = -1;
    int         en_cyc_prev = -1;
    logic [3:0] data_prev   = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enable) begin
            en_total    <= en_total + 1;
            en_cyc_prev <= en_cyc_last;
            en_cyc_last <= cyc;
        end
        if (frame_err) fe_total <= fe_total + 1;
        if (enable && frame_err) both_hi <= both_hi + 1;
        if (rst_n && !enable && (data !== data_prev)) data_glitch <= data_glitch + 1;
        data_prev <= data;
    end

    typedef struct {
        logic [3:0] nib;
        logic       par;
        logic       stop;
        int         exp_en;
        int         exp_fe;
        logic [3:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] nib, input logic par, input logic stop,
                                input int exp_en, input int exp_fe, input logic [3:0] exp_data);
        vec_t v;
        v.nib = nib; v.par = par; v.stop = stop;
        v.exp_en = exp_en; v.exp_fe = exp_fe; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] nib, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(nib[i]);
`ifdef NIBBLE_PARITY_CHECK_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        send_bit(stop);
    endtask

    int en0, fe0;

    initial begin
        // nib, even-parity bit, stop, expected enables, expected frame_errs, expected data
        tbl.push_back(mk(4'hA, 1'b0, 1'b1, 1, 0, 4'hA));
        tbl.push_back(mk(4'h3, 1'b0, 1'b1, 1, 0, 4'h3));
        tbl.push_back(mk(4'hC, 1'b0, 1'b1, 1, 0, 4'hC));
        tbl.push_back(mk(4'h5, 1'b0, 1'b0, 0, 1, 4'hC));
        tbl.push_back(mk(4'hF, 1'b0, 1'b1, 1, 0, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1, 0, 4'h0));
        tbl.push_back(mk(4'h1, 1'b1, 1'b1, 1, 0, 4'h1));
        tbl.push_back(mk(4'h8, 1'b1, 1'b1, 1, 0, 4'h8));
`ifdef NIBBLE_PARITY_CHECK_EN
        tbl.push_back(mk(4'h7, 1'b1, 1'b1, 1, 0, 4'h7));
        tbl.push_back(mk(4'h6, 1'b0, 1'b1, 1, 0, 4'h6));
        tbl.push_back(mk(4'h7, 1'b0, 1'b1, 0, 1, 4'h6));
        tbl.push_back(mk(4'hE, 1'b0, 1'b0, 0, 1, 4'h6));
`endif

        // Reset held for 3 clk with the line toggling: all outputs stay at reset values.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset cyc%0d {data,en,fe,busy}", i),
                  {27'd0, data, enable, frame_err, busy}, 32'd0);
            sin = ~sin;
        end
        sin   = 1'b1;
        rst_n = 1'b1;
        tick(3);
        check("idle after reset busy", {31'd0, busy}, 32'd0);

        // Table of single frames, each followed by a short idle gap.
        for (int i = 0; i < tbl.size(); i++) begin
            en0 = en_total;
            fe0 = fe_total;
            send_frame(tbl[i].nib, tbl[i].par, tbl[i].stop);
            sin = 1'b1;
            tick(3);
            check($sformatf("vec%0d enable count", i), en_total - en0, tbl[i].exp_en);
            check($sformatf("vec%0d frame_err count", i), fe_total - fe0, tbl[i].exp_fe);
            check($sformatf("vec%0d data", i), {28'd0, data}, {28'd0, tbl[i].exp_data});
            check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
        end

        // Back-to-back frames with no idle gap.
        en0 = en_total;
        send_frame(4'h3, 1'b0, 1'b1);
        check("b2b first data", {28'd0, data}, 32'h3);
        send_frame(4'hC, 1'b0, 1'b1);
        sin = 1'b1;
        tick(3);
        check("b2b enable count", en_total - en0, 2);
        check("b2b pulse spacing", en_cyc_last - en_cyc_prev, FRAME_CLKS);
        check("b2b second data", {28'd0, data}, 32'hC);

        // Bad stop bit followed by a held-low line.
        en0 = en_total;
        fe0 = fe_total;
        send_frame(4'h5, 1'b0, 1'b0);
        tick(20);
        check("break busy held", {31'd0, busy}, 32'd1);
        check("break frame_err count", fe_total - fe0, 1);
        check("break enable count", en_total - en0, 0);
        check("break data unchanged", {28'd0, data}, 32'hC);
        sin = 1'b1;
        tick(1);
        check("break release busy", {31'd0, busy}, 32'd0);

        // One-clock glitch on the line.
        en0 = en_total;
        fe0 = fe_total;
        sin = 1'b0;
        tick(1);
        check("glitch busy rises", {31'd0, busy}, 32'd1);
        sin = 1'b1;
        tick(6);
        check("glitch busy back", {31'd0, busy}, 32'd0);
        check("glitch no pulses", (en_total - en0) + (fe_total - fe0), 0);

        // Reset in the middle of the data bits of frame 0x9.
        en0 = en_total;
        fe0 = fe_total;
        send_bit(1'b0);
        send_bit(1'b1);
        sin = 1'b0;
        tick(2);
        check("mid-frame busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("mid-frame reset {data,en,fe,busy}",
              {27'd0, data, enable, frame_err, busy}, 32'd0);
        rst_n = 1'b1;
        sin   = 1'b1;
        tick(30);
        check("after abort pulses", (en_total - en0) + (fe_total - fe0), 0);
        check("after abort data", {28'd0, data}, 32'h0);
        check("after abort busy", {31'd0, busy}, 32'd0);

        // Whole-run invariants from the monitor.
        check("enable and frame_err together", both_hi, 0);
        check("data changed without enable", data_glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_loader.md
Name: nibble_serial_loader

Overview:
- Serial-to-parallel front end that drives the data/enable load interface of the team's 4-bit D flip-flop register.
- Receives an asynchronous-style serial frame on one wire, assembles a 4-bit word, and presents it on `data` with a single-cycle `enable` strobe.
- Sits between an external serial line and the 4-bit register; it is the producer end of that register's load interface.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit period (even value, >= 4).
- CNT_W, 8, width of the internal bit-period counter (must hold CLKS_PER_BIT-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- sin  input  1  serial line, idle high. Synchronous to clk; no internal synchronizer.
- data  output  4  assembled word, connects to the register's data input.
- enable  output  1  one-cycle load strobe, connects to the register's enable input.
- frame_err  output  1  one-cycle pulse on a bad stop bit (or parity failure, see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock, synchronous, active-low (clk rising edge with rst_n=0).
  - Reset values: data=4'h0, enable=0, frame_err=0, busy=0, state=IDLE, counters=0.
  - Reset mid-frame abandons the frame: no enable, no frame_err.
- Frame format: 1 start bit (0), 4 data bits LSB first, [parity bit], 1 stop bit (1).
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE: when sin==0, go to START with bit counter=0.
  - START: after CLKS_PER_BIT/2 cycles, re-sample sin.
    - sin==0: go to DATA, reset the period counter.
    - sin==1: treat as a glitch; return to IDLE with no outputs.
  - DATA: every CLKS_PER_BIT cycles, sample sin into shift register bit [idx], idx 0..3. After idx 3, go to PARITY (if enabled) or STOP.
  - STOP: after CLKS_PER_BIT cycles, sample sin.
    - sin==1: next cycle data<=shift register and enable=1 for exactly one cycle; go to IDLE.
    - sin==0: frame_err=1 for one cycle, data unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until sin==1, then go to IDLE. This prevents a held-low (break) line from retriggering.
- Outputs:
  - data holds its last value between loads; it changes only in the cycle enable is high.
  - enable and frame_err are never high in the same cycle. Each is at most one pulse per frame.
  - Back-to-back frames: a new start bit is accepted in the first IDLE cycle after the enable pulse. No dead time beyond that cycle.
- Counter: the period counter wraps to 0 at CLKS_PER_BIT-1. No arithmetic overflow is possible for legal parameters.

Optional Feature:
- Macro: NIBBLE_PARITY_CHECK_EN.
- Defined:
  - PARITY state is inserted after DATA and samples one bit period.
  - Even parity is required: the XOR of the 4 data bits and the parity bit must be 0.
  - On mismatch, the frame still completes through STOP. At the stop sample, frame_err pulses instead of enable, regardless of the stop bit value. Next state is WAIT_HIGH if sin==0, else IDLE.
- Undefined: no PARITY state; frames are 6 bits long. There is no parity bit in the frame.

Test Plan (CLKS_PER_BIT=4, parity macro undefined unless stated):
- Reset: hold rst_n=0 for 3 clk with sin toggling -> data=0, enable=0, frame_err=0, busy=0 throughout. No activity until rst_n=1.
- Single frame: send 0xA (bits 0,1,0,1 LSB first) with valid stop -> exactly one enable pulse, data=4'hA from that cycle onward, frame_err never high.
- Back-to-back: frames 0x3 then 0xC with no idle gap -> two enable pulses, data 4'h3 then 4'hC, pulses spaced 24 clk apart.
- Framing error: send 0x5 with stop bit 0, then hold sin low 20 clk -> one frame_err pulse, no enable, data unchanged, busy high until sin returns 1.
- Glitch and reset: sin low for 1 clk only -> return to IDLE with no pulse. Then assert rst_n=0 mid-DATA of frame 0x9 -> no enable, outputs at reset values.
- With NIBBLE_PARITY_CHECK_EN: 0x7 with parity bit 1 -> enable, data=4'h7. 0x7 with parity bit 0 -> frame_err, no enable.
